generic_mux_scanner: RTL
========================

GENERIC_MUX_SCANNER -- requirements
Module: generic_mux_scanner

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of mux channels scanned (N >= 2).
REQ-002 The block SHALL have parameter DWELL, default 2, giving the settle cycles per channel before sampling (DWELL >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: scan request, sampled only in IDLE.
REQ-006 The block SHALL have port mask, input, N bits: 1 = skip that channel; sampled only on start acceptance.
REQ-007 The block SHALL have port y_in, input, 1 bit: the selected bit returned from the downstream N:1 mux.
REQ-008 The block SHALL have port sel, output, $clog2(N) bits: the channel select driven to the downstream mux.
REQ-009 The block SHALL have port busy, output, 1 bit: high in SETTLE and SAMPLE.
REQ-010 The block SHALL have port snapshot, output, N bits: the captured channel values from the last scan.
REQ-011 The block SHALL have port valid, output, 1 bit: snapshot ready; high only in DONE.
REQ-012 The block SHALL have port ready, input, 1 bit: consumer accepts snapshot.

Function
REQ-013 The FSM SHALL have four states: IDLE, SETTLE, SAMPLE and DONE; all outputs SHALL be registered.
REQ-014 In IDLE with start=1 and mask not all ones, the block SHALL clear snapshot, latch mask, load sel with the lowest unmasked index, clear the dwell counter and go to SETTLE.
REQ-015 In IDLE with start=1 and mask all ones, the block SHALL set snapshot=0, keep sel unchanged and go directly to DONE.
REQ-016 In SETTLE, the block SHALL hold sel, increment the counter each cycle and go to SAMPLE on the edge where counter == DWELL-1; SETTLE therefore lasts exactly DWELL cycles.
REQ-017 SAMPLE SHALL last 1 cycle; at its closing edge the block SHALL set snapshot[sel] <= y_in.
REQ-018 At the same closing edge, the block SHALL load sel with the next higher unmasked index and go to SETTLE with counter=0 if one exists, else go to DONE.
REQ-019 Masked channels SHALL read 0 in snapshot.
REQ-020 Latency: with K unmasked channels, valid SHALL rise exactly K*(DWELL+1) cycles after the start-accepting edge (12 for N=4, DWELL=2, mask=0).
REQ-021 In DONE, valid=1; snapshot and sel SHALL hold until valid && ready, then the block SHALL go to IDLE with valid=0.
REQ-022 start SHALL be ignored outside IDLE, including the DONE handshake cycle; a new scan SHALL be accepted no earlier than the cycle after return to IDLE.
REQ-023 mask changes after acceptance SHALL have no effect on the scan in progress.
REQ-024 sel SHALL never present an index >= N; the index search SHALL not wrap past N-1.

Reset
REQ-025 When rst=1, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, sel=0, counter=0, snapshot=0, busy=0 and valid=0, including mid-scan or in DONE.
REQ-026 After rst deasserts, the block SHALL wait in IDLE for a fresh start; no scan SHALL resume.

Verification (N=4, DWELL=2, downstream mux instantiated with a static data bus)
REQ-027 data=1010, mask=0000, 1-cycle start pulse -> sel=0,1,2,3 each held 3 cycles; valid rises 12 cycles after the start edge; snapshot=1010.
REQ-028 data=1111, mask=0101 -> sel visits 1 then 3 only; valid after 6 cycles; snapshot=1010.
REQ-029 mask=1111, start -> valid=1 the next cycle, snapshot=0000, sel=0, busy never high.
REQ-030 In DONE, ready=0 for 5 cycles with start pulsed -> valid and snapshot stable, no new scan; ready=1 -> valid=0 next cycle, IDLE.
REQ-031 rst asserted mid-SETTLE on channel 2 -> sel, snapshot, busy and valid go to 0 before the next clk edge; after release, start gives a normal 12-cycle scan.
REQ-032 start held high through the handshake cycle -> second scan accepted on the edge after return to IDLE; snapshot cleared at that edge.

Source files
------------

// File: rtl/generic_mux_scanner.sv
// Sequencer that steps a downstream N:1 mux across its unmasked channels,
// lets each selection settle for DWELL cycles, then captures the returned bit.
module generic_mux_scanner #(
  parameter int unsigned N     = 4,
  parameter int unsigned DWELL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N-1:0]         mask,
  input  logic                 y_in,
  input  logic                 ready,
  output logic [$clog2(N)-1:0] sel,
  output logic                 busy,
  output logic [N-1:0]         snapshot,
  output logic                 valid
);

  localparam int unsigned SW = $clog2(N);
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [SW-1:0]  r_sel;
  logic [SW-1:0]  w_sel_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [N-1:0]   r_mask;
  logic [N-1:0]   w_mask_nxt;
  logic [N-1:0]   r_snap;
  logic [N-1:0]   w_snap_nxt;
  logic           r_busy;
  logic           w_busy_nxt;
  logic           r_valid;
  logic           w_valid_nxt;

  logic [SW-1:0]  w_first_idx;
  logic           w_first_found;
  logic [SW-1:0]  w_next_idx;
  logic           w_next_found;

  // Lowest unmasked channel of the incoming mask, and next unmasked channel above sel.
  always_comb begin
    w_first_idx   = '0;
    w_first_found = 1'b0;
    w_next_idx    = '0;
    w_next_found  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!mask[i] && !w_first_found) begin
        w_first_idx   = SW'(i);
        w_first_found = 1'b1;
      end
      if (!r_mask[i] && (SW'(i) > r_sel) && !w_next_found) begin
        w_next_idx   = SW'(i);
        w_next_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    w_snap_nxt  = r_snap;
    w_busy_nxt  = 1'b0;
    w_valid_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mask_nxt = mask;
          w_snap_nxt = '0;
          if (w_first_found) begin
            w_sel_nxt   = w_first_idx;
            w_cnt_nxt   = '0;
            w_state_nxt = S_SETTLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(DWELL - 1)) begin
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w_snap_nxt[r_sel] = y_in;
        if (w_next_found) begin
          w_sel_nxt   = w_next_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (r_valid && ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Flags follow the state being entered so they line up with it after the edge.
    w_busy_nxt  = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE);
    w_valid_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_snap  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mask  <= w_mask_nxt;
      r_snap  <= w_snap_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign sel      = r_sel;
  assign busy     = r_busy;
  assign snapshot = r_snap;
  assign valid    = r_valid;

endmodule
